// File: rtl/pc_stack_pkg.sv
// Shared op encoding and strobe decode for the PC / return-stack unit.
// Controller and counter both use pc_decode so priority stays consistent.
package pc_stack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_SKIP,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_ILLEGAL
  } op_t;

  function automatic op_t pc_decode(
    input logic load,
    input logic call,
    input logic ret,
    input logic skip,
    input logic enab
  );
    op_t op;
    if (load)
      op = OP_LOAD;
    else if (call && ret)
      op = OP_ILLEGAL;
    else if (call)
      op = OP_CALL;
    else if (ret)
      op = OP_RET;
    else if (skip)
      op = OP_SKIP;
    else if (enab)
      op = OP_INC;
    else
      op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_counter_if.sv
// Controller <-> PC/RAS bundle: strobes in, PC and stack status out.
// master = controller side, slave = counter side.
interface pc_stack_counter_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
);

  logic [WIDTH-1:0]           cnt_in;
  logic                       load;
  logic                       call;
  logic                       ret;
  logic                       skip;
  logic                       enab;
  logic                       clr_err;
  logic [WIDTH-1:0]           cnt_out;
  logic                       wrap;
  logic [$clog2(DEPTH+1)-1:0] ras_count;
  logic                       ras_empty;
  logic                       ras_full;
  logic                       ras_ovf;
  logic                       ras_unf;

  modport master (
    output cnt_in, load, call, ret, skip, enab, clr_err,
    input  cnt_out, wrap, ras_count, ras_empty, ras_full,
    input  ras_ovf, ras_unf
  );

  modport slave (
    input  cnt_in, load, call, ret, skip, enab, clr_err,
    output cnt_out, wrap, ras_count, ras_empty, ras_full,
    output ras_ovf, ras_unf
  );

endinterface

// File: rtl/ras_lifo.sv
// Circular return-address stack; a push when full overwrites the oldest.
// Overflow/underflow are reported as single-cycle event pulses.
module ras_lifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic             do_pop;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign do_pop   = pop && !empty;
  assign ovf      = push && full;
  assign unf      = pop && empty;
  assign top_idx  = ptr - 1'b1;
  assign top_data = mem[top_idx];

  // ptr marks the next free slot; when full it lands on the oldest entry
  always_ff @(posedge clk) begin
    if (push)
      mem[ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (!full)
        count <= count + 1'b1;
    end else if (do_pop) begin
      ptr   <= top_idx;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with load/inc/skip and call/return via ras_lifo.
// Owns PC, wrap pulse and the sticky stack error flags.
module pc_stack_counter
  import pc_stack_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  pc_stack_counter_if.slave bus
);

  op_t              op;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_skip;
  logic [WIDTH-1:0] top_data;
  logic             stk_empty;
  logic             stk_full;
  logic             ovf_ev;
  logic             unf_ev;
  logic             wrap_q;
  logic             ovf_q;
  logic             unf_q;

  assign op      = pc_decode(bus.load, bus.call, bus.ret,
                             bus.skip, bus.enab);
  assign pc_inc  = pc + WIDTH'(1);
  assign pc_skip = pc + WIDTH'(2);

  ras_lifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (op == OP_CALL),
    .pop       (op == OP_RET),
    .push_data (pc_inc),
    .top_data  (top_data),
    .count     (bus.ras_count),
    .full      (stk_full),
    .empty     (stk_empty),
    .ovf       (ovf_ev),
    .unf       (unf_ev)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_VAL;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (op)
        OP_INC: begin
          pc     <= pc_inc;
          wrap_q <= pc_inc < pc;
        end
        OP_SKIP: begin
          pc     <= pc_skip;
          wrap_q <= pc_skip < pc;
        end
        OP_LOAD, OP_CALL: pc <= bus.cnt_in;
        OP_RET: begin
          if (!stk_empty)
            pc <= top_data;
        end
        default: pc <= pc;
      endcase
      // a new error event wins over a same-cycle clear
      ovf_q <= ovf_ev || (ovf_q && !bus.clr_err);
      unf_q <= unf_ev || (op == OP_ILLEGAL) ||
               (unf_q && !bus.clr_err);
    end
  end

  assign bus.cnt_out   = pc;
  assign bus.wrap      = wrap_q;
  assign bus.ras_empty = stk_empty;
  assign bus.ras_full  = stk_full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Vector-table bench for pc_stack_counter (WIDTH=5, DEPTH=4).
// Expected state is queued on drive and popped after the edge.
module tb_pc_stack_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pc_stack_counter_if #(.WIDTH(5), .DEPTH(4)) bus ();

  pc_stack_counter #(
    .WIDTH     (5),
    .DEPTH     (4),
    .RESET_VAL (5'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       ld, cl, rt, sk, en, ce;
    logic [4:0] din;
    logic [4:0] cnt;
    logic       wr;
    logic [2:0] cntr;
    logic       ovf, unf;
  } vec_t;

  typedef struct {
    logic [4:0] cnt;
    logic       wr;
    logic [2:0] cntr;
    logic       ovf, unf;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic ld, cl, rt, sk, en, ce,
    input logic [4:0] din, cnt,
    input logic wr,
    input logic [2:0] cntr,
    input logic ovf, unf
  );
    vec_t v;
    v.ld = ld; v.cl = cl; v.rt = rt; v.sk = sk;
    v.en = en; v.ce = ce; v.din = din; v.cnt = cnt;
    v.wr = wr; v.cntr = cntr; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d want %0d",
               name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.load    = v.ld;
    bus.call    = v.cl;
    bus.ret     = v.rt;
    bus.skip    = v.sk;
    bus.enab    = v.en;
    bus.clr_err = v.ce;
    bus.cnt_in  = v.din;
  endtask

  task automatic check_out(input exp_t e);
    chk("cnt_out", e.idx, 32'(bus.cnt_out), 32'(e.cnt));
    chk("wrap", e.idx, 32'(bus.wrap), 32'(e.wr));
    chk("ras_count", e.idx, 32'(bus.ras_count), 32'(e.cntr));
    chk("ras_empty", e.idx, 32'(bus.ras_empty),
        32'(e.cntr == 3'd0));
    chk("ras_full", e.idx, 32'(bus.ras_full),
        32'(e.cntr == 3'd4));
    chk("ras_ovf", e.idx, 32'(bus.ras_ovf), 32'(e.ovf));
    chk("ras_unf", e.idx, 32'(bus.ras_unf), 32'(e.unf));
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.cnt = v.cnt; e.wr = v.wr; e.cntr = v.cntr;
    e.ovf = v.ovf; e.unf = v.unf; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty want entry",
               idx);
    end else begin
      check_out(sb.pop_front());
    end
  endtask

  initial begin
    exp_t r;
    drive(mk(0,0,0,0,0,0, 5'd0, 5'd0, 0, 3'd0, 0, 0));
    #12;
    r = '{cnt: 5'd0, wr: 0, cntr: 3'd0, ovf: 0, unf: 0, idx: -1};
    check_out(r);
    rst = 1'b1;

    // async reset: reach pc=9 with one stacked entry, reset mid-cycle
    step(mk(0,1,0,0,0,0, 5'd9, 5'd9, 0, 3'd1, 0, 0), 900);
    #1 rst = 1'b0;
    #1;
    r = '{cnt: 5'd0, wr: 0, cntr: 3'd0, ovf: 0, unf: 0, idx: 901};
    check_out(r);
    rst = 1'b1;

    //               ld cl rt sk en ce din  cnt  wr cnt ov un
    vecs.push_back(mk(1,0,0,0,0,0, 5'd30, 5'd30, 0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 5'd0,  5'd31, 0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 5'd0,  5'd0,  1,3'd0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 5'd0,  5'd0,  0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 5'd31, 5'd31, 0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 5'd0,  5'd1,  1,3'd0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 5'd0,  5'd1,  0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 5'd4,  5'd4,  0,3'd0,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 5'd20, 5'd20, 0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 5'd3,  5'd3,  0,3'd0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd10, 5'd10, 0,3'd1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 5'd0,  5'd11, 0,3'd1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd17, 5'd17, 0,3'd2,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd12, 0,3'd1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd4,  0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 5'd0,  5'd0,  0,3'd0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd1,  5'd1,  0,3'd1,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd2,  5'd2,  0,3'd2,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd3,  5'd3,  0,3'd3,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd4,  5'd4,  0,3'd4,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd0,  5'd0,  0,3'd4,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd5,  0,3'd3,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd4,  0,3'd2,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd3,  0,3'd1,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd2,  0,3'd0,1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd2,  0,3'd0,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 5'd0,  5'd2,  0,3'd0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 5'd6,  5'd6,  0,3'd0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd7,  5'd7,  0,3'd1,0,0));
    vecs.push_back(mk(0,1,1,0,0,0, 5'd15, 5'd7,  0,3'd1,0,1));
    vecs.push_back(mk(0,0,0,0,0,1, 5'd0,  5'd7,  0,3'd1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd7,  0,3'd0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1, 5'd0,  5'd7,  0,3'd0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0, 5'd0,  5'd7,  0,3'd0,0,1));
    vecs.push_back(mk(1,0,0,0,0,1, 5'd31, 5'd31, 0,3'd0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0, 5'd3,  5'd3,  0,3'd1,0,0));
    vecs.push_back(mk(0,0,1,0,0,0, 5'd0,  5'd0,  0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0, 5'd0,  5'd2,  0,3'd0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 5'd0,  5'd3,  0,3'd0,0,0));

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], i);

    // reset asserted while a call is being strobed
    @(negedge clk);
    drive(mk(0,1,0,0,0,0, 5'd12, 5'd0, 0, 3'd0, 0, 0));
    #2 rst = 1'b0;
    #1;
    r = '{cnt: 5'd0, wr: 0, cntr: 3'd0, ovf: 0, unf: 0, idx: 950};
    check_out(r);
    @(posedge clk);
    #1;
    r.idx = 951;
    check_out(r);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
